// File: rtl/cellrv32_rst_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cellrv32_rst_ctrl
// Description : System reset controller. Merges the external reset pin, the
//               watchdog bite and the debug-module non-debug reset into one
//               registered internal reset. Each internal reset is held low for
//               a minimum width. The block also records what caused the last
//               reset.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   EXT_SYNC_STAGES : synchronizer depth for external reset release (2..4)
//   HOLD_CYCLES     : minimum internal reset low-time in clocks (1..255)
// Ports
//   clk_i       in  1  global clock
//   rstn_ext_i  in  1  external reset, asynchronous, active-low
//   wdt_rstn_i  in  1  watchdog bite, synchronous, active-low, may be 1 cycle
//   dbg_rstn_i  in  1  debug reset request, synchronous, active-low, level
//   rstn_sys_o  out 1  external reset: async assert, synchronized release
//   rstn_int_o  out 1  internal system reset, active-low, registered
//   cause_o     out 2  last reset cause (00 ext, 01 watchdog, 10 debug)
//   rst_cnt_o   out 8  saturating count of internal resets since ext reset
// ============================================================================
module cellrv32_rst_ctrl #(
  parameter int EXT_SYNC_STAGES = 2,
  parameter int HOLD_CYCLES     = 16
) (
  input  logic       clk_i,
  input  logic       rstn_ext_i,
  input  logic       wdt_rstn_i,
  input  logic       dbg_rstn_i,
  output logic       rstn_sys_o,
  output logic       rstn_int_o,
  output logic [1:0] cause_o,
  output logic [7:0] rst_cnt_o
);

  // Counter value loaded when a hold window opens: the load edge itself
  // counts as the first low cycle, so HOLD_CYCLES-1 remaining edges follow.
  localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);
  // While debug is still requesting reset the counter is parked one higher,
  // so the full HOLD_CYCLES low cycles start with the first clock that sees
  // the request released.
  localparam logic [7:0] HOLD_DBG  = 8'(HOLD_CYCLES);

  localparam logic [1:0] CAUSE_EXT = 2'b00;
  localparam logic [1:0] CAUSE_WDT = 2'b01;
  localparam logic [1:0] CAUSE_DBG = 2'b10;

  typedef enum logic [1:0] {
    ST_EXT  = 2'd0,
    ST_HOLD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  logic [EXT_SYNC_STAGES-1:0] sync_q, sync_d;
  state_t                     state_q, state_d;
  logic [7:0]                 hold_cnt_q, hold_cnt_d;
  logic                       rstn_int_q, rstn_int_d;
  logic [1:0]                 cause_q, cause_d;
  logic [7:0]                 rst_cnt_q, rst_cnt_d;

  // Release synchronizer: ones shift in from the bottom after the pin rises.
  assign sync_d = {sync_q[EXT_SYNC_STAGES-2:0], 1'b1};

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    rstn_int_d = rstn_int_q;
    cause_d    = cause_q;
    rst_cnt_d  = rst_cnt_q;

    case (state_q)
      ST_EXT: begin
        rstn_int_d = 1'b0;
        if (sync_q[EXT_SYNC_STAGES-1]) begin
          hold_cnt_d = HOLD_LOAD;
          state_d    = ST_HOLD;
        end
      end

      ST_HOLD: begin
        // Watchdog is deliberately not looked at here: it is being held in
        // reset by us, and a stray bite must not extend or recount.
        rstn_int_d = 1'b0;
        if (!dbg_rstn_i) begin
          hold_cnt_d = HOLD_DBG;
        end else if (hold_cnt_q == 8'd0) begin
          rstn_int_d = 1'b1;
          state_d    = ST_RUN;
        end else begin
          hold_cnt_d = hold_cnt_q - 8'd1;
        end
      end

      ST_RUN: begin
        rstn_int_d = 1'b1;
        if (!wdt_rstn_i || !dbg_rstn_i) begin
          rstn_int_d = 1'b0;
          hold_cnt_d = HOLD_LOAD;
          state_d    = ST_HOLD;
          // Watchdog takes precedence on a simultaneous request.
          cause_d    = (!wdt_rstn_i) ? CAUSE_WDT : CAUSE_DBG;
          if (rst_cnt_q != 8'hFF) begin
            rst_cnt_d = rst_cnt_q + 8'd1;
          end
        end
      end

      default: begin
        rstn_int_d = 1'b0;
        state_d    = ST_EXT;
      end
    endcase
  end

  // Everything here is cleared only by the external pin; internal resets
  // never touch the cause/count registers.
  always_ff @(posedge clk_i or negedge rstn_ext_i) begin
    if (!rstn_ext_i) begin
      sync_q     <= '0;
      state_q    <= ST_EXT;
      hold_cnt_q <= 8'd0;
      rstn_int_q <= 1'b0;
      cause_q    <= CAUSE_EXT;
      rst_cnt_q  <= 8'd0;
    end else begin
      sync_q     <= sync_d;
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      rstn_int_q <= rstn_int_d;
      cause_q    <= cause_d;
      rst_cnt_q  <= rst_cnt_d;
    end
  end

  assign rstn_sys_o = sync_q[EXT_SYNC_STAGES-1];
  assign rstn_int_o = rstn_int_q;
  assign cause_o    = cause_q;
  assign rst_cnt_o  = rst_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_cellrv32_rst_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_cellrv32_rst_ctrl
// Description : Self-checking bench for cellrv32_rst_ctrl. A default-parameter
//               instance is exercised through a table of internal reset
//               vectors with a scoreboard queue; a second instance with
//               HOLD_CYCLES=1 and three sync stages shares the stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cellrv32_rst_ctrl;

  logic       clk;
  logic       rstn_ext;
  logic       wdt_rstn;
  logic       dbg_rstn;
  logic       rstn_sys_o, rstn_int_o;
  logic [1:0] cause_o;
  logic [7:0] rst_cnt_o;
  logic       rstn_sys_1, rstn_int_1;
  logic [1:0] cause_1;
  logic [7:0] rst_cnt_1;

  cellrv32_rst_ctrl #(.EXT_SYNC_STAGES(2), .HOLD_CYCLES(16)) dut (
    .clk_i(clk), .rstn_ext_i(rstn_ext), .wdt_rstn_i(wdt_rstn),
    .dbg_rstn_i(dbg_rstn), .rstn_sys_o(rstn_sys_o), .rstn_int_o(rstn_int_o),
    .cause_o(cause_o), .rst_cnt_o(rst_cnt_o)
  );

  cellrv32_rst_ctrl #(.EXT_SYNC_STAGES(3), .HOLD_CYCLES(1)) dut1 (
    .clk_i(clk), .rstn_ext_i(rstn_ext), .wdt_rstn_i(wdt_rstn),
    .dbg_rstn_i(dbg_rstn), .rstn_sys_o(rstn_sys_1), .rstn_int_o(rstn_int_1),
    .cause_o(cause_1), .rst_cnt_o(rst_cnt_1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         wdt;       // single-cycle watchdog bite at the trigger edge
    int         dbg_len;   // number of edges debug request is sampled low
    int         wdt2_at;   // extra bite sampled this many edges later (-1 none)
    logic [1:0] exp_cause;
    int         exp_low;   // expected low cycles of the default instance
    int         exp_low1;  // expected low cycles of HOLD_CYCLES=1 instance
  } vec_t;

  typedef struct {
    logic [1:0] cause;
    int         cnt;
    int         low;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   exp_cnt  = 0;
  vec_t vecs[7];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Releases the external pin and records on which edge each output rises.
  task automatic ext_release();
    int sys_e, int_e, sys1_e, int1_e;
    sys_e = -1; int_e = -1; sys1_e = -1; int1_e = -1;
    @(negedge clk);
    rstn_ext = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (sys_e  < 0 && rstn_sys_o === 1'b1) sys_e  = k;
      if (int_e  < 0 && rstn_int_o === 1'b1) int_e  = k;
      if (sys1_e < 0 && rstn_sys_1 === 1'b1) sys1_e = k;
      if (int1_e < 0 && rstn_int_1 === 1'b1) int1_e = k;
    end
    check("rstn_sys_rise_edge", sys_e, 2);
    check("rstn_int_rise_edge", int_e, 19);
    check("h1_rstn_sys_rise_edge", sys1_e, 3);
    check("h1_rstn_int_rise_edge", int1_e, 5);
    check("cause_after_release", int'(cause_o), 0);
    check("cnt_after_release", int'(rst_cnt_o), 0);
    check("h1_cause_after_release", int'(cause_1), 0);
    check("h1_cnt_after_release", int'(rst_cnt_1), 0);
    exp_cnt = 0;
  endtask

  // Fires one internal reset vector from RUN and measures the low window.
  task automatic run_vec(input vec_t v, input string tag);
    exp_t e;
    int   low, low1;
    bit   done;
    if (exp_cnt != 255) exp_cnt++;
    e.cause = v.exp_cause;
    e.cnt   = exp_cnt;
    e.low   = v.exp_low;
    sb.push_back(e);

    @(negedge clk);
    wdt_rstn = v.wdt ? 1'b0 : 1'b1;
    dbg_rstn = (v.dbg_len > 0) ? 1'b0 : 1'b1;
    low = 0; low1 = 0; done = 1'b0;
    for (int k = 1; k <= 200 && !done; k++) begin
      @(negedge clk);
      wdt_rstn = (k == v.wdt2_at) ? 1'b0 : 1'b1;
      if (k >= v.dbg_len) dbg_rstn = 1'b1;
      if (rstn_int_o === 1'b1) done = 1'b1;
      else low++;
      if (rstn_int_1 !== 1'b1) low1++;
    end
    wdt_rstn = 1'b1;
    dbg_rstn = 1'b1;
    check({tag, "_release_seen"}, int'(done), 1);

    e = sb.pop_front();
    check({tag, "_low_cycles"}, low, e.low);
    check({tag, "_cause"}, int'(cause_o), int'(e.cause));
    check({tag, "_rst_cnt"}, int'(rst_cnt_o), e.cnt);
    if (v.exp_low1 >= 0) check({tag, "_h1_low_cycles"}, low1, v.exp_low1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t w;
    //            wdt  dbg_len wdt2 cause  low  low1
    vecs[0] = '{1'b1, 0,      -1,  2'b01, 16,  1};
    vecs[1] = '{1'b0, 1,      -1,  2'b10, 16, -1};
    vecs[2] = '{1'b0, 40,     -1,  2'b10, 56, -1};
    vecs[3] = '{1'b1, 1,      -1,  2'b01, 16, -1};
    vecs[4] = '{1'b1, 5,      -1,  2'b01, 21, -1};
    vecs[5] = '{1'b0, 3,      -1,  2'b10, 19, -1};
    vecs[6] = '{1'b1, 0,       5,  2'b01, 16, -1};

    rstn_ext = 1'b0;
    wdt_rstn = 1'b1;
    dbg_rstn = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_rstn_sys", int'(rstn_sys_o), 0);
    check("reset_rstn_int", int'(rstn_int_o), 0);
    check("reset_cause", int'(cause_o), 0);
    check("reset_rst_cnt", int'(rst_cnt_o), 0);

    ext_release();

    for (int i = 0; i < 7; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // External reset landing in the middle of a hold window.
    @(negedge clk);
    wdt_rstn = 1'b0;
    @(negedge clk);
    wdt_rstn = 1'b1;
    repeat (4) @(negedge clk);
    check("midhold_in_reset", int'(rstn_int_o), 0);
    check("midhold_cause_before", int'(cause_o), 1);
    check("midhold_cnt_before", int'(rst_cnt_o), 8);
    #2 rstn_ext = 1'b0;
    #1;
    check("midhold_rstn_sys", int'(rstn_sys_o), 0);
    check("midhold_rstn_int", int'(rstn_int_o), 0);
    check("midhold_cause_cleared", int'(cause_o), 0);
    check("midhold_cnt_cleared", int'(rst_cnt_o), 0);
    ext_release();

    // Saturation: 260 watchdog resets.
    w = vecs[0];
    w.exp_low1 = -1;
    for (int i = 0; i < 260; i++) begin
      run_vec(w, "sat");
    end
    check("sat_final_cnt", int'(rst_cnt_o), 255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
